// File: rtl/psum_writeback_pkg.sv
// Shared types and helpers for the partial-sum writeback stage.
// Holds the FSM state encoding and the per-lane saturating add.
package psum_writeback_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_RD,
        ST_ADD,
        ST_WR,
        ST_DONE
    } state_e;

    // Operands arrive sign-extended to 64 bits; bw is the real lane width (<= 32).
    // The wide sum cannot overflow, so clamping against the bw-bit range is exact.
    function automatic logic signed [63:0] sat_add_lane(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        bw
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_writeback_sat_add.sv
// Column-parallel saturating adder: col independent signed lanes, no carry
// between lanes.
module psum_sat_add
    import psum_writeback_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic [psum_bw*col-1:0] a_i,
    input  logic [psum_bw*col-1:0] b_i,
    output logic [psum_bw*col-1:0] sum_o
);

    for (genvar i = 0; i < col; i++) begin : g_lane
        assign sum_o[i*psum_bw +: psum_bw] = psum_bw'(sat_add_lane(
            64'($signed(a_i[i*psum_bw +: psum_bw])),
            64'($signed(b_i[i*psum_bw +: psum_bw])),
            psum_bw));
    end

endmodule

// File: rtl/psum_writeback.sv
// Drains OFIFO partial-sum vectors into the psum SRAM at consecutive
// addresses, optionally accumulating onto the stored vector with saturation.
module psum_writeback
    import psum_writeback_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   acc_en,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [len_bw-1:0]      len,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_data,
    output logic                   ofifo_rd,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [addr_bw-1:0]     mem_addr,
    output logic [psum_bw*col-1:0] mem_d,
    input  logic [psum_bw*col-1:0] mem_q,
    output logic                   busy,
    output logic                   done
);

    state_e                 state_q, state_d;
    logic                   acc_q;
    logic [len_bw-1:0]      len_q;
    logic [len_bw-1:0]      cnt_q;
    logic [addr_bw-1:0]     ptr_q;
    logic [psum_bw*col-1:0] hold_q;
    logic [psum_bw*col-1:0] sum;

    logic                   mem_cen_q, mem_wen_q, busy_q, done_q;
    logic [addr_bw-1:0]     mem_addr_q;
    logic [psum_bw*col-1:0] mem_d_q;

    psum_sat_add #(
        .psum_bw(psum_bw),
        .col    (col)
    ) u_sat_add (
        .a_i  (hold_q),
        .b_i  (mem_q),
        .sum_o(sum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = (len == '0) ? ST_DONE : ST_POP;
            ST_POP:  if (ofifo_valid) state_d = acc_q ? ST_RD : ST_WR;
            ST_RD:   state_d = ST_ADD;
            ST_ADD:  state_d = ST_WR;
            ST_WR:   state_d = (cnt_q == len_q - len_bw'(1)) ? ST_DONE : ST_POP;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs are registered from the next state, so they line up
    // with the cycle the FSM actually sits in RD or WR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            mem_cen_q  <= 1'b1;
            mem_wen_q  <= 1'b1;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            mem_cen_q <= !((state_d == ST_RD) || (state_d == ST_WR));
            mem_wen_q <= (state_d != ST_WR);
            if ((state_d == ST_RD) || (state_d == ST_WR)) begin
                mem_addr_q <= ptr_q;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q <= acc_en;
                        len_q <= len;
                        cnt_q <= '0;
                        ptr_q <= base_addr;
                    end
                end
                ST_POP: begin
                    if (ofifo_valid) begin
                        hold_q <= ofifo_data;
                        if (!acc_q) mem_d_q <= ofifo_data;
                    end
                end
                ST_ADD: begin
                    hold_q  <= sum;
                    mem_d_q <= sum;
                end
                ST_WR: begin
                    ptr_q <= ptr_q + addr_bw'(1);
                    cnt_q <= cnt_q + len_bw'(1);
                end
                default: ;
            endcase
        end
    end

    assign ofifo_rd = (state_q == ST_POP) && ofifo_valid;
    assign mem_cen  = mem_cen_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;
    assign mem_d    = mem_d_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
